// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scanner: scan phase,
// digit count, bundle width and the active-high hex glyph table.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_phase_e;

    localparam int NumDigits = 4;
    localparam int BundleW   = 20;

    // Segment order is {g,f,e,d,c,b,a}, a segment is lit when its bit is 1.
    localparam logic [6:0] HexSegTable [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-digit to seven-segment decoder, active-high output.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    assign seg_o = HexSegTable[value_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit seven-segment display, fed by a
// digit bundle from the slow game clock domain.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int CyclesPerDigit = 100000,
    parameter int BlankCycles    = 1000,
    parameter bit ActiveLow      = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       digit0_en_i,
    input  logic [3:0] digit0_i,
    input  logic       digit1_en_i,
    input  logic [3:0] digit1_i,
    input  logic       digit2_en_i,
    input  logic [3:0] digit2_i,
    input  logic       digit3_en_i,
    input  logic [3:0] digit3_i,
    output logic [3:0] anode_o,
    output logic [6:0] segments_o,
    output logic       dp_o
);

    localparam int                CntW     = $clog2(CyclesPerDigit);
    localparam logic [CntW-1:0]   CntMax   = CntW'(CyclesPerDigit - 1);
    localparam logic [CntW-1:0]   BlankCnt = CntW'(BlankCycles);
    localparam logic [NumDigits-1:0] AnodeOff = {NumDigits{ActiveLow}};
    localparam logic [6:0]        SegOff   = {7{ActiveLow}};
    localparam logic              DpOff    = ActiveLow;

    logic [BundleW-1:0] bundle_in;
    logic [BundleW-1:0] sync1, sync2, sync3;
    logic [BundleW-1:0] shadow;
    logic               stable;

    logic [CntW-1:0]    cnt, cnt_next;
    logic [1:0]         slot;
    scan_phase_e        phase;
    logic               cnt_last, frame_wrap, blank_next;

    logic               digit_en;
    logic [3:0]         digit_val;
    logic [6:0]         seg_hex;
    logic               lit;

    assign bundle_in = {digit3_en_i, digit3_i, digit2_en_i, digit2_i,
                        digit1_en_i, digit1_i, digit0_en_i, digit0_i};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= bundle_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // A bundle that differs between consecutive stages was caught mid-change.
    assign stable = (sync2 == sync3);

    assign cnt_last   = (cnt == CntMax);
    assign frame_wrap = cnt_last && (slot == 2'd3);
    assign cnt_next   = cnt_last ? '0 : cnt + 1'b1;
    assign blank_next = (cnt_next < BlankCnt);

    // NOTE: the shadow is reset to all-zero so every digit starts disabled;
    // it only ever updates at a frame boundary, which keeps a frame tear-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow <= '0;
        end else if (frame_wrap && stable) begin
            shadow <= sync2;
        end
    end

    // NOTE: every variable in always_comb gets a default first so a missed
    // case arm cannot infer a latch.
    always_comb begin
        digit_en  = 1'b0;
        digit_val = 4'h0;
        case (slot)
            2'd0: {digit_en, digit_val} = shadow[4:0];
            2'd1: {digit_en, digit_val} = shadow[9:5];
            2'd2: {digit_en, digit_val} = shadow[14:10];
            2'd3: {digit_en, digit_val} = shadow[19:15];
            default: ;
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .value_i (digit_val),
        .seg_o   (seg_hex)
    );

    assign lit = (phase == ON) && digit_en;

    // Slot/phase scan FSM with registered, polarity-adjusted outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt        <= '0;
            slot       <= 2'd0;
            phase      <= BLANK;
            anode_o    <= AnodeOff;
            segments_o <= SegOff;
            dp_o       <= DpOff;
        end else begin
            cnt <= cnt_next;
            if (cnt_last) begin
                slot <= slot + 2'd1;
            end
            case (phase)
                BLANK:   phase <= blank_next ? BLANK : ON;
                ON:      phase <= blank_next ? BLANK : ON;
                default: phase <= BLANK;
            endcase
            anode_o    <= (lit ? (4'b0001 << slot) : 4'b0000) ^ AnodeOff;
            segments_o <= (lit ? seg_hex : 7'h00) ^ SegOff;
            dp_o       <= DpOff;
        end
    end

endmodule
